// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce_edge input-conditioning block.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b10,
    S_WAIT_LOW  = 2'b11
  } state_e;

  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by async active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic d_sync
);

  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= d_async;
      sync2_q <= sync1_q;
    end
  end

  assign d_sync = sync2_q;

endmodule

// File: rtl/debounce_edge.sv
// Synchronises a raw level, rejects pulses shorter than STABLE_CYCLES clocks and
// produces a clean level, its complement and one-cycle rise/fall strobes.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic             sync2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_async(d),
    .d_sync (sync2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // cnt defaults to zero so every non-counting arm clears it, ahead of any increment.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync2) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = CntOne;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync2) begin
          state_d = S_LOW;
        end else if (cnt_q == CntLast) begin
          state_d = S_HIGH;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      S_HIGH: begin
        if (!sync2) begin
          state_d = S_WAIT_LOW;
          cnt_d   = CntOne;
        end
      end
      S_WAIT_LOW: begin
        if (sync2) begin
          state_d = S_HIGH;
        end else if (cnt_q == CntLast) begin
          state_d = S_LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = S_LOW;
    endcase
  end

  // The upper state bit is the debounced level, so q is a registered value with no extra flop.
  assign q    = state_q[1];
  assign qbar = ~q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Randomised and directed bench for debounce_edge at STABLE_CYCLES = 2, 4 and 16.
module tb_debounce_edge;
  import debounce_pkg::*;

  localparam int NI = 3;

  logic          clk;
  logic          rst;
  logic          d;
  logic [NI-1:0] q_w, qbar_w, rise_w, fall_w;

  int n_checks;
  int n_errors;
  int gr[NI];
  int gf[NI];

  function automatic int stab(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  debounce_edge #(.STABLE_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .d(d), .q(q_w[0]), .qbar(qbar_w[0]), .rise(rise_w[0]), .fall(fall_w[0])
  );
  debounce_edge #(.STABLE_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .d(d), .q(q_w[1]), .qbar(qbar_w[1]), .rise(rise_w[1]), .fall(fall_w[1])
  );
  debounce_edge #(.STABLE_CYCLES(16)) u16 (
    .clk(clk), .rst(rst), .d(d), .q(q_w[2]), .qbar(qbar_w[2]), .rise(rise_w[2]), .fall(fall_w[2])
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: after a two-sample delay, q flips once the delayed input has
  // disagreed with q for STABLE consecutive samples; the flip sample strobes.
  logic [NI-1:0] m_s1, m_s2, m_q, m_rise, m_fall;
  int            m_run[NI];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1   <= '0;
      m_s2   <= '0;
      m_q    <= '0;
      m_rise <= '0;
      m_fall <= '0;
      for (int i = 0; i < NI; i++) m_run[i] <= 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_s1[i]   <= d;
        m_s2[i]   <= m_s1[i];
        m_rise[i] <= 1'b0;
        m_fall[i] <= 1'b0;
        if (m_s2[i] != m_q[i]) begin
          if (m_run[i] + 1 == stab(i)) begin
            m_q[i]    <= m_s2[i];
            m_rise[i] <= m_s2[i];
            m_fall[i] <= !m_s2[i];
            m_run[i]  <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
    end
  end

  // Continuous comparison against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check_eq($sformatf("q_s%0d", stab(i)), q_w[i], m_q[i]);
        check_eq($sformatf("qbar_s%0d", stab(i)), qbar_w[i], !m_q[i]);
        check_eq($sformatf("rise_s%0d", stab(i)), rise_w[i], m_rise[i]);
        check_eq($sformatf("fall_s%0d", stab(i)), fall_w[i], m_fall[i]);
        check_eq($sformatf("excl_s%0d", stab(i)), rise_w[i] & fall_w[i], 0);
      end
      check_eq("cnt_bound_s2", {31'b0, u2.cnt_q > 2'd1}, 0);
      check_eq("cnt_bound_s4", {31'b0, u4.cnt_q > 3'd3}, 0);
      check_eq("cnt_bound_s16", {31'b0, u16.cnt_q > 5'd15}, 0);
    end
  end

  // Advance n cycles, ending 5 units after a rising edge, tallying strobes.
  task automatic run_watch(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (rise_w[i]) gr[i]++;
        if (fall_w[i]) gf[i]++;
      end
      #4;
    end
  endtask

  task automatic clear_tally();
    for (int i = 0; i < NI; i++) begin
      gr[i] = 0;
      gf[i] = 0;
    end
  endtask

  // Called just after d changes; expects one strobe on edge 2+STABLE for masked instances.
  task automatic measure(input bit want_rise, input logic [NI-1:0] mask, input string tag);
    int first[NI];
    int cnt[NI];
    for (int i = 0; i < NI; i++) begin
      first[i] = 0;
      cnt[i]   = 0;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        logic s;
        s = want_rise ? rise_w[i] : fall_w[i];
        if (s) begin
          cnt[i]++;
          if (first[i] == 0) first[i] = k;
        end
      end
    end
    #4;
    for (int i = 0; i < NI; i++) begin
      if (mask[i]) begin
        check_eq($sformatf("%s_edge_s%0d", tag, stab(i)), first[i], 2 + stab(i));
        check_eq($sformatf("%s_pulses_s%0d", tag, stab(i)), cnt[i], 1);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_tally();
    d   = 1'b1;
    rst = 1'b1;

    // Reset held with d=1: outputs stay at reset values.
    repeat (2) begin
      @(posedge clk);
      #1;
      check_eq("rst_q", q_w, 3'b000);
      check_eq("rst_qbar", qbar_w, 3'b111);
      check_eq("rst_strobes", {rise_w, fall_w}, 6'b0);
    end
    #4;
    rst = 1'b0;
    measure(1'b1, 3'b111, "rst_release");

    // Clean fall then rise.
    d = 1'b0;
    measure(1'b0, 3'b111, "clean_fall");
    d = 1'b1;
    measure(1'b1, 3'b111, "clean_rise");

    // Glitch low for 3 cycles from q=1.
    clear_tally();
    d = 1'b0;
    run_watch(3);
    d = 1'b1;
    run_watch(30);
    check_eq("glitch_lo_fall_s4", gf[1], 0);
    check_eq("glitch_lo_fall_s16", gf[2], 0);
    check_eq("glitch_lo_q", q_w[2:1], 2'b11);

    // Glitch high for 3 cycles from q=0.
    d = 1'b0;
    run_watch(30);
    clear_tally();
    d = 1'b1;
    run_watch(3);
    d = 1'b0;
    run_watch(30);
    check_eq("glitch_hi_rise_s4", gf[1] + gr[1], 0);
    check_eq("glitch_hi_rise_s16", gr[2], 0);
    check_eq("glitch_hi_q", q_w[2:1], 2'b00);

    // Exactly STABLE=4 cycles high is accepted.
    clear_tally();
    d = 1'b1;
    run_watch(4);
    d = 1'b0;
    run_watch(30);
    check_eq("exact4_rise_s4", gr[1], 1);
    check_eq("exact4_fall_s4", gf[1], 1);
    check_eq("exact4_rise_s16", gr[2], 0);

    // 3 high, 1 low, then held: counting restarts at the final rise.
    d = 1'b1;
    run_watch(3);
    d = 1'b0;
    run_watch(1);
    d = 1'b1;
    measure(1'b1, 3'b110, "restart");

    // Asynchronous reset while u4 is in S_WAIT_HIGH with cnt=2.
    d = 1'b0;
    run_watch(30);
    d = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("mid_setup_state", u4.state_q, S_WAIT_HIGH);
    check_eq("mid_setup_cnt", u4.cnt_q, 2);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_q", q_w, 3'b000);
    check_eq("mid_qbar", qbar_w, 3'b111);
    check_eq("mid_state", u4.state_q, S_LOW);
    check_eq("mid_cnt", u4.cnt_q, 0);
    check_eq("mid_strobes", {rise_w, fall_w}, 6'b0);
    @(posedge clk);
    #5;
    rst = 1'b0;
    measure(1'b1, 3'b111, "mid_release");

    // Random run lengths with occasional asynchronous reset pulses.
    for (int s = 0; s < 250; s++) begin
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        #3;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
      end
      run_watch(int'($urandom_range(1, 20)));
    end

    run_watch(4);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
